// File: rtl/bip_defs.sv
// Shared definitions for the BIP run controller: FSM state encoding, frame
// status bytes, default command/opcode values and the frame-length helper.
package bip_defs;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_LATCH,
        ST_SEND
    } run_state_t;

    localparam logic [7:0] STATUS_HALT       = 8'h48;  // 'H'
    localparam logic [7:0] STATUS_TIMEOUT    = 8'h54;  // 'T'
    localparam logic [7:0] START_CMD_DEFAULT = 8'h73;  // 's'
    localparam logic [4:0] HALT_OPCODE_DEFAULT = 5'b00000;

    // Status byte, then the cycle count, then the accumulator.
    function automatic int frame_bytes(input int cyc_bits, input int data_width);
        return 1 + cyc_bits / 8 + data_width / 8;
    endfunction

endpackage

// File: rtl/bip_tx_frame_serializer.sv
// Captures an N-byte frame in parallel and presents it byte 0 first over a
// valid/ready handshake; done marks the cycle the final byte is accepted.
module bip_tx_frame_serializer #(
    parameter int N_BYTES = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [N_BYTES*8-1:0] frame,
    input  logic                 tx_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    output logic                 done
);

    localparam int IDX_BITS = $clog2(N_BYTES);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N_BYTES - 1);

    logic [7:0]          bytes_q [N_BYTES];
    logic [IDX_BITS-1:0] idx;
    logic                busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the buffer is only a few bytes of flops, so it is reset like any
            // other register; a stale frame can never leak out after an abort.
            for (int i = 0; i < N_BYTES; i++) bytes_q[i] <= '0;
            idx  <= '0;
            busy <= 1'b0;
        end else if (load) begin
            for (int i = 0; i < N_BYTES; i++) bytes_q[i] <= frame[i*8 +: 8];
            idx  <= '0;
            busy <= 1'b1;
        end else if (busy && tx_ready) begin
            if (idx == LAST_IDX) begin
                busy <= 1'b0;
                idx  <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign done     = busy && tx_ready && (idx == LAST_IDX);
    assign tx_valid = busy;
    // Index only advances on acceptance, so the byte holds steady through a stall.
    assign tx_data  = busy ? bytes_q[idx] : 8'h00;

endmodule

// File: rtl/bip_run_controller.sv
// Sequences one BIP run for the UART debug flow: start byte, CPU clear, counted
// run until HALT or timeout, then a status/cycle-count/accumulator frame out.
module bip_run_controller
    import bip_defs::*;
#(
    parameter int                     DATA_WIDTH  = 16,
    parameter int                     OPCODE_BITS = 5,
    parameter logic [OPCODE_BITS-1:0] HALT_OPCODE = OPCODE_BITS'(HALT_OPCODE_DEFAULT),
    parameter int                     CYC_BITS    = 32,
    parameter longint unsigned        MAX_CYCLES  = 64'd1 << 20,
    parameter logic [7:0]             START_CMD   = START_CMD_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic [OPCODE_BITS-1:0] instr_opcode,
    input  logic [DATA_WIDTH-1:0]  acc,
    output logic                   cpu_en,
    output logic                   cpu_clear,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   running,
    output logic                   halted
);

    localparam int N_BYTES = frame_bytes(CYC_BITS, DATA_WIDTH);
    localparam logic [CYC_BITS-1:0] LAST_CYCLE = CYC_BITS'(MAX_CYCLES - 64'd1);

    run_state_t          state, state_next;
    logic [CYC_BITS-1:0] cycle_cnt;
    logic [7:0]          status;
    logic                halt_hit;
    logic                timeout_hit;
    logic                frame_done;

    assign halt_hit    = (instr_opcode == HALT_OPCODE);
    assign timeout_hit = (cycle_cnt == LAST_CYCLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: defaulting every output of a combinational block first is what
        // keeps a missed branch from inferring a latch.
        state_next = state;
        case (state)
            ST_IDLE:  if (rx_valid && rx_data == START_CMD) state_next = ST_CLEAR;
            ST_CLEAR: state_next = ST_RUN;
            ST_RUN:   if (halt_hit || timeout_hit) state_next = ST_LATCH;
            ST_LATCH: state_next = ST_SEND;
            ST_SEND:  if (frame_done) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // The final RUN cycle is still counted, so LATCH sees the true total.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
            status    <= 8'h00;
            halted    <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    cycle_cnt <= '0;
                    halted    <= 1'b0;
                end
                ST_RUN: begin
                    cycle_cnt <= cycle_cnt + 1'b1;
                    status    <= halt_hit ? STATUS_HALT : STATUS_TIMEOUT;
                end
                ST_LATCH: halted <= (status == STATUS_HALT);
                default: ;
            endcase
        end
    end

    assign cpu_en    = (state == ST_RUN);
    assign cpu_clear = (state == ST_CLEAR);
    assign running   = (state == ST_CLEAR) || (state == ST_RUN);

    bip_tx_frame_serializer #(
        .N_BYTES (N_BYTES)
    ) u_serializer (
        .clk      (clk),
        .reset    (reset),
        .load     (state == ST_LATCH),
        .frame    ({acc, cycle_cnt, status}),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .done     (frame_done)
    );

endmodule

// File: tb/tb_bip_run_controller.sv
// Bench for bip_run_controller: table of directed runs, hand-written reset and
// stray-byte sequences, and random runs against a behavioural frame model.
module tb_bip_run_controller;

    localparam int MAX_CYC = 16;
    localparam int N_BYTES = 7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [4:0]  instr_opcode;
    logic [15:0] acc = 16'h0000;
    logic        cpu_en, cpu_clear, tx_valid, running, halted;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;

    bip_run_controller #(
        .DATA_WIDTH  (16),
        .OPCODE_BITS (5),
        .HALT_OPCODE (5'b00000),
        .CYC_BITS    (32),
        .MAX_CYCLES  (64'd16),
        .START_CMD   (8'h73)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .instr_opcode (instr_opcode),
        .acc          (acc),
        .cpu_en       (cpu_en),
        .cpu_clear    (cpu_clear),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .running      (running),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_total++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // CPU stand-in: reports HALT on the halt_at-th enabled cycle (0 = never halts).
    int halt_at = 0;
    int run_count = 0;
    int clr_total = 0;
    int stall_viol = 0;
    logic       was_stalled = 1'b0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] byte_log[$];

    assign instr_opcode = (halt_at != 0 && run_count == halt_at) ? 5'b00000 : 5'b00011;

    always @(negedge clk) begin
        if (cpu_clear) begin
            run_count <= 0;
            clr_total <= clr_total + 1;
        end else if (cpu_en) begin
            run_count <= run_count + 1;
        end
        if (reset && tx_valid && tx_ready) byte_log.push_back(tx_data);
        if (tx_valid && !tx_ready) begin
            if (was_stalled && tx_data !== last_data) stall_viol <= stall_viol + 1;
            was_stalled <= 1'b1;
            last_data   <= tx_data;
        end else begin
            was_stalled <= 1'b0;
        end
    end

    // tx_ready modes: 0 always ready, 1 five idle cycles before each byte, 2 random.
    int mode = 0;
    initial begin
        int wait_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: tx_ready = 1'b1;
                1: begin
                    if (!tx_valid) begin
                        tx_ready = 1'b0;
                        wait_cnt = 0;
                    end else if (wait_cnt < 5) begin
                        tx_ready = 1'b0;
                        wait_cnt++;
                    end else begin
                        tx_ready = 1'b1;
                        wait_cnt = 0;
                    end
                end
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Reference model: a run ends on the HALT cycle if that comes within the
    // budget, otherwise after exactly MAX_CYC cycles with a timeout status.
    task automatic model(input int h, output logic [7:0] st, output int cnt, output bit hl);
        if (h >= 1 && h <= MAX_CYC) begin
            st = 8'h48; cnt = h; hl = 1'b1;
        end else begin
            st = 8'h54; cnt = MAX_CYC; hl = 1'b0;
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i, input logic [7:0] st, input int cnt,
                                            input logic [15:0] a);
        logic [31:0] c;
        c = 32'(cnt);
        if (i == 0)      return st;
        else if (i <= 4) return c[(i-1)*8 +: 8];
        else             return a[(i-5)*8 +: 8];
    endfunction

    task automatic wait_frame(input string tag, input int base_b);
        int n = 0;
        while (!((byte_log.size() - base_b) >= N_BYTES && !tx_valid && !running) && n < 500) begin
            tick();
            n++;
        end
        check({tag, ".finished_in_time"}, 64'(n < 500), 64'd1);
    endtask

    task automatic compare_run(input string tag, input int base_b, input int base_c, input int base_v,
                               input logic [7:0] st, input int cnt, input logic [15:0] a, input bit hl);
        check({tag, ".byte_count"}, 64'(byte_log.size() - base_b), 64'(N_BYTES));
        for (int i = 0; i < N_BYTES; i++)
            check($sformatf("%s.byte%0d", tag, i), 64'(byte_log[base_b + i]), 64'(exp_byte(i, st, cnt, a)));
        check({tag, ".cpu_en_cycles"}, 64'(run_count), 64'(cnt));
        check({tag, ".clear_pulses"}, 64'(clr_total - base_c), 64'd1);
        check({tag, ".halted"}, 64'(halted), 64'(hl));
        check({tag, ".stall_stable"}, 64'(stall_viol - base_v), 64'd0);
    endtask

    task automatic do_run(input string tag, input int h, input logic [15:0] a, input int m,
                          input logic [7:0] st, input int cnt, input bit hl);
        int base_b, base_c, base_v;
        halt_at = h;
        acc     = a;
        mode    = m;
        base_b  = byte_log.size();
        base_c  = clr_total;
        base_v  = stall_viol;
        send_byte(8'h73);
        wait_frame(tag, base_b);
        compare_run(tag, base_b, base_c, base_v, st, cnt, a, hl);
    endtask

    typedef struct {
        int          halt_at;
        logic [15:0] acc;
        int          mode;
        logic [7:0]  st;
        int          cnt;
        bit          hl;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{10, 16'h1234, 0, 8'h48, 10, 1'b1};  // halt on 10th cycle
        vecs[1] = '{10, 16'h1234, 1, 8'h48, 10, 1'b1};  // same run, stalled transmitter
        vecs[2] = '{0,  16'hBEEF, 0, 8'h54, 16, 1'b0};  // no HALT: timeout
        vecs[3] = '{1,  16'h00FF, 0, 8'h48, 1,  1'b1};  // HALT as first instruction
        vecs[4] = '{16, 16'hA55A, 2, 8'h48, 16, 1'b1};  // halt and timeout together
        vecs[5] = '{17, 16'h0001, 0, 8'h54, 16, 1'b0};  // halt one cycle too late

        #2;
        check("reset.cpu_en",    64'(cpu_en),    64'd0);
        check("reset.cpu_clear", 64'(cpu_clear), 64'd0);
        check("reset.tx_valid",  64'(tx_valid),  64'd0);
        check("reset.tx_data",   64'(tx_data),   64'd0);
        check("reset.running",   64'(running),   64'd0);
        check("reset.halted",    64'(halted),    64'd0);
        #20;
        reset = 1'b1;
        tick();

        // Stray bytes in IDLE must not start a run.
        send_byte(8'h00);
        send_byte(8'h41);
        repeat (4) tick();
        check("idle_junk.running", 64'(running), 64'd0);
        check("idle_junk.clears",  64'(clr_total), 64'd0);

        foreach (vecs[i])
            do_run($sformatf("vec%0d", i), vecs[i].halt_at, vecs[i].acc, vecs[i].mode,
                   vecs[i].st, vecs[i].cnt, vecs[i].hl);

        // A second start byte during RUN is dropped: one frame only.
        begin
            int base_b, base_c, base_v;
            halt_at = 10; acc = 16'h1234; mode = 0;
            base_b = byte_log.size(); base_c = clr_total; base_v = stall_viol;
            send_byte(8'h73);
            repeat (3) tick();
            send_byte(8'h73);
            wait_frame("rerun", base_b);
            repeat (30) tick();
            compare_run("rerun", base_b, base_c, base_v, 8'h48, 10, 16'h1234, 1'b1);
            check("rerun.running_after", 64'(running), 64'd0);
        end

        // Asynchronous reset while byte 3 is on the wire.
        begin
            int base_b, n;
            halt_at = 10; acc = 16'hCAFE; mode = 1;
            base_b = byte_log.size();
            send_byte(8'h73);
            n = 0;
            while ((byte_log.size() - base_b) < 3 && n < 300) begin
                tick();
                n++;
            end
            check("abort.reached_byte3", 64'(n < 300), 64'd1);
            check("abort.halted_before", 64'(halted), 64'd1);
            @(posedge clk);
            #3;
            reset = 1'b0;
            #1;
            check("abort.cpu_en",    64'(cpu_en),    64'd0);
            check("abort.cpu_clear", 64'(cpu_clear), 64'd0);
            check("abort.tx_valid",  64'(tx_valid),  64'd0);
            check("abort.tx_data",   64'(tx_data),   64'd0);
            check("abort.running",   64'(running),   64'd0);
            check("abort.halted",    64'(halted),    64'd0);
            #12;
            reset = 1'b1;
            repeat (3) tick();
            check("abort.no_resume", 64'(tx_valid), 64'd0);
            do_run("fresh", 10, 16'h1234, 1, 8'h48, 10, 1'b1);
        end

        // Random runs against the model, with random transmitter back-pressure.
        for (int r = 0; r < 20; r++) begin
            int h, cnt;
            logic [15:0] a;
            logic [7:0] st;
            bit hl;
            h = $urandom_range(0, 24);
            a = 16'($urandom);
            model(h, st, cnt, hl);
            do_run($sformatf("rand%0d", r), h, a, 2, st, cnt, hl);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
